dmem_responder: RTL

- Data-memory responder: the target end of the core's dmem request interface (req_val/rw/addr/wdata in, resp_data out).
- Sits in the test harness beside the instruction memory.
- Holds a word-addressed RAM plus two test-rig MMIO registers (tohost, fromhost).
- Inserts a programmable number of wait states so the core's stall logic can be exercised.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dmem target with word RAM, tohost/fromhost MMIO and programmable wait states
// Requests are captured at accept and resolved on the commit edge that enters RESP.
module dmem_responder #(
    parameter int          ADDR_WIDTH    = 10,
    parameter int          LATENCY       = 1,
    parameter logic [31:0] TOHOST_ADDR   = 32'h0000_1000,
    parameter logic [31:0] FROMHOST_ADDR = 32'h0000_1004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req_val,
    input  logic        dmem_req_rw,
    input  logic [31:0] dmem_req_addr,
    input  logic [31:0] dmem_req_wdata,
    output logic        dmem_req_rdy,
    output logic        dmem_resp_val,
    output logic [31:0] dmem_resp_data,
    output logic        dmem_resp_err,
    output logic        testrig_tohost,
    output logic [31:0] tohost_data,
    input  logic        testrig_fromhost
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [3:0] LAT     = 4'(LATENCY);
    localparam int         DEPTH   = 1 << ADDR_WIDTH;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] mem_q [DEPTH];

    logic                  accept;
    logic                  commit;
    logic                  c_rw;
    logic [31:0]           c_addr;
    logic [31:0]           c_wdata;
    logic                  in_ram;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  mem_we;

    // Ready is forced low while reset is held so every output reads 0.
    assign dmem_req_rdy   = rst & (state_q != ST_WAIT);
    assign accept         = dmem_req_val & dmem_req_rdy;
    assign dmem_resp_val  = (state_q == ST_RESP);
    assign dmem_resp_data = resp_data_q;
    assign dmem_resp_err  = resp_err_q;
    assign tohost_data    = tohost_q;
    assign testrig_tohost = |tohost_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            rw_d    = dmem_req_rw;
            addr_d  = dmem_req_addr;
            wdata_d = dmem_req_wdata;
        end
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    state_d = (LAT == 4'd0) ? ST_RESP : ST_WAIT;
                    cnt_d   = LAT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the accept edge is also the commit edge, so decode the live inputs.
    assign commit  = (state_d == ST_RESP);
    assign c_rw    = (state_q == ST_WAIT) ? rw_q    : dmem_req_rw;
    assign c_addr  = (state_q == ST_WAIT) ? addr_q  : dmem_req_addr;
    assign c_wdata = (state_q == ST_WAIT) ? wdata_q : dmem_req_wdata;
    assign in_ram  = ({2'b00, c_addr[31:2]} < 32'(DEPTH));
    assign idx     = c_addr[ADDR_WIDTH+1:2];

    always_comb begin
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        tohost_d    = tohost_q;
        mem_we      = 1'b0;
        if (commit) begin
            resp_data_d = 32'd0;
            resp_err_d  = 1'b0;
            if (c_addr[1:0] != 2'b00) begin
                resp_err_d = 1'b1;
            end else if (c_addr == TOHOST_ADDR) begin
                if (c_rw) tohost_d    = c_wdata;
                else      resp_data_d = tohost_q;
            end else if (c_addr == FROMHOST_ADDR) begin
                if (!c_rw) resp_data_d = {31'd0, testrig_fromhost};
            end else if (in_ram) begin
                if (c_rw) mem_we      = 1'b1;
                else      resp_data_d = mem_q[idx];
            end else begin
                resp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rw_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
            tohost_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            tohost_q    <= tohost_d;
        end
    end

    // RAM is not reset; the rst term drops a store whose commit edge meets reset.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            mem_q[idx] <= c_wdata;
        end
    end

endmodule
